soft_reset_ctrl: RTL and testbench

- Multi-channel, parametrised successor of the single-channel soft reset block.
- Each channel turns a CSR soft-reset request into a sequence:
  1. Assert a "block" (quiesce) signal.
  2. Wait for the channel to report idle, or time out.
  3. Drive a reset pulse of programmable length.
  4. Signal completion.
- Sits between the CSR register file and the MAC/DMA sub-blocks of the Ethernet controller.
- One instance serves all sub-blocks.

---
 rtl/soft_reset_pkg.sv | 30 +++
 rtl/soft_reset_chan.sv | 98 +++++++++
 rtl/soft_reset_ctrl.sv | 48 ++++
 tb/tb_soft_reset_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/soft_reset_pkg.sv
// Shared types and elaboration helpers for the multi-channel soft reset controller.
package soft_reset_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLOCK = 2'd1,
    ST_RESET = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

  // Counter must hold values up to max(RST_CYC, TMO_CYC)-1 without wrapping.
  function automatic int unsigned cnt_width(input int unsigned rst_cyc, input int unsigned tmo_cyc);
    int unsigned m;
    m = (rst_cyc > tmo_cyc) ? rst_cyc : tmo_cyc;
    return clog2(m + 1);
  endfunction

  function automatic bit params_ok(input int unsigned nch, input int unsigned rst_cyc,
                                   input int unsigned tmo_cyc);
    return (nch >= 1) && (rst_cyc >= 1) && (tmo_cyc >= 1);
  endfunction

endpackage

// File: rtl/soft_reset_chan.sv
// One soft reset channel: quiesce, wait for idle or timeout, pulse reset, strobe done.
module soft_reset_chan
  import soft_reset_pkg::*;
#(
  parameter int unsigned RST_CYC = 4,
  parameter int unsigned TMO_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic idle,
  output logic block,
  output logic reset,
  output logic done,
  output logic tmo
);

  localparam int unsigned CW = cnt_width(RST_CYC, TMO_CYC);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYC - 1);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_tmo;
  logic          w_tmo_nxt;
  logic          r_block;
  logic          r_reset;
  logic          r_done;

  // Outputs are decoded from the next state so they flop alongside the state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_tmo   <= 1'b0;
      r_block <= 1'b0;
      r_reset <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tmo   <= w_tmo_nxt;
      r_block <= (w_state_nxt != ST_IDLE);
      r_reset <= (w_state_nxt == ST_RESET);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tmo_nxt   = r_tmo;
    case (r_state)
      ST_IDLE: begin
        if (req) begin
          w_state_nxt = ST_BLOCK;
          w_cnt_nxt   = '0;
          w_tmo_nxt   = 1'b0;
        end
      end
      ST_BLOCK: begin
        if (idle) begin
          w_state_nxt = ST_RESET;
          w_cnt_nxt   = '0;
        end else if (r_cnt == TMO_LAST) begin
          w_state_nxt = ST_RESET;
          w_cnt_nxt   = '0;
          w_tmo_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_RESET: begin
        if (r_cnt == RST_LAST) begin
          w_state_nxt = ST_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign block = r_block;
  assign reset = r_reset;
  assign done  = r_done;
  assign tmo   = r_tmo;

endmodule

// File: rtl/soft_reset_ctrl.sv
// Multi-channel soft reset controller: one independent sequencer per sub-block.
module soft_reset_ctrl
  import soft_reset_pkg::*;
#(
  parameter int unsigned NCH     = 2,
  parameter int unsigned RST_CYC = 4,
  parameter int unsigned TMO_CYC = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] sr_req,
  input  logic           sr_all,
  input  logic [NCH-1:0] idle,
  output logic [NCH-1:0] block,
  output logic [NCH-1:0] reset,
  output logic [NCH-1:0] done,
  output logic [NCH-1:0] tmo,
  output logic           busy
);

  logic [NCH-1:0] w_req;

  if (!params_ok(NCH, RST_CYC, TMO_CYC)) begin : g_param_err
    $error("soft_reset_ctrl: NCH, RST_CYC and TMO_CYC must all be >= 1");
  end

  assign w_req = sr_req | {NCH{sr_all}};

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    soft_reset_chan #(
      .RST_CYC(RST_CYC),
      .TMO_CYC(TMO_CYC)
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .req  (w_req[i]),
      .idle (idle[i]),
      .block(block[i]),
      .reset(reset[i]),
      .done (done[i]),
      .tmo  (tmo[i])
    );
  end

  // A channel is outside IDLE exactly when its block output is high.
  assign busy = |block;

endmodule

// File: tb/tb_soft_reset_ctrl.sv
// Scoreboard bench: expected per-cycle output vectors are derived from sequence timing.
module tb_soft_reset_ctrl;

  localparam int unsigned NCYC = 48;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sr_req;
  logic       sr_all;
  logic [1:0] idle;
  logic [1:0] block, reset, done, tmo;
  logic       busy;

  logic [0:0] l_req, l_idle, l_block, l_reset, l_done, l_tmo;
  logic       l_busy;

  always #5 clk = ~clk;

  soft_reset_ctrl #(.NCH(2), .RST_CYC(4), .TMO_CYC(8)) u_dut (
    .clk(clk), .rst(rst), .sr_req(sr_req), .sr_all(sr_all), .idle(idle),
    .block(block), .reset(reset), .done(done), .tmo(tmo), .busy(busy)
  );

  soft_reset_ctrl #(.NCH(1), .RST_CYC(1), .TMO_CYC(1)) u_dut_leg (
    .clk(clk), .rst(rst), .sr_req(l_req), .sr_all(1'b0), .idle(l_idle),
    .block(l_block), .reset(l_reset), .done(l_done), .tmo(l_tmo), .busy(l_busy)
  );

  // Channels 0,1 belong to the main instance, channel 2 to the legacy-style instance.
  logic       st_rst  [NCYC];
  logic [1:0] st_req  [NCYC];
  logic       st_all  [NCYC];
  logic [1:0] st_idle [NCYC];
  logic       st_lreq [NCYC];
  logic       st_lidle[NCYC];
  logic       eb[3][NCYC];
  logic       er[3][NCYC];
  logic       ed[3][NCYC];
  logic       et[3][NCYC];
  logic       carry_tmo[3];

  logic [13:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic clear_scen();
    for (int k = 0; k < NCYC; k++) begin
      st_rst[k]   = 1'b1;
      st_req[k]   = 2'b00;
      st_all[k]   = 1'b0;
      st_idle[k]  = 2'b11;
      st_lreq[k]  = 1'b0;
      st_lidle[k] = 1'b1;
      for (int c = 0; c < 3; c++) begin
        eb[c][k] = 1'b0;
        er[c][k] = 1'b0;
        ed[c][k] = 1'b0;
        et[c][k] = carry_tmo[c];
      end
    end
  endtask

  // Accepted at edge k0, BLOCK lasts t cycles, reset lasts rc cycles, then done.
  task automatic plan(input int c, input int k0, input int t, input int rc, input logic to);
    int l;
    l = k0 + t;
    for (int k = k0; k <= l + rc && k < NCYC; k++) eb[c][k] = 1'b1;
    for (int k = l; k < l + rc && k < NCYC; k++) er[c][k] = 1'b1;
    if (l + rc < NCYC) ed[c][l + rc] = 1'b1;
    for (int k = k0; k < NCYC; k++) et[c][k] = (k >= l) ? to : 1'b0;
  endtask

  task automatic apply_rst(input int ka, input int kb);
    for (int k = ka; k <= kb; k++) st_rst[k] = 1'b0;
    for (int k = ka; k < NCYC; k++)
      for (int c = 0; c < 3; c++) begin
        eb[c][k] = 1'b0;
        er[c][k] = 1'b0;
        ed[c][k] = 1'b0;
        et[c][k] = 1'b0;
      end
  endtask

  function automatic logic [13:0] exp_vec(input int k);
    return {eb[0][k] | eb[1][k], et[1][k], et[0][k], ed[1][k], ed[0][k],
            er[1][k], er[0][k], eb[1][k], eb[0][k],
            eb[2][k], et[2][k], ed[2][k], er[2][k], eb[2][k]};
  endfunction

  task automatic run_scen(input int s);
    logic [13:0] got;
    logic [13:0] exp;
    @(negedge clk);
    for (int k = 0; k < NCYC; k++) begin
      rst    = st_rst[k];
      sr_req = st_req[k];
      sr_all = st_all[k];
      idle   = st_idle[k];
      l_req  = st_lreq[k];
      l_idle = st_lidle[k];
      exp_q.push_back(exp_vec(k));
      @(posedge clk);
      @(negedge clk);
      got = {busy, tmo, done, reset, block, l_busy, l_tmo, l_done, l_reset, l_block};
      exp = exp_q.pop_front();
      check($sformatf("s%0d_k%0d", s, k), got, exp);
    end
    for (int c = 0; c < 3; c++) carry_tmo[c] = et[c][NCYC-1];
  endtask

  initial begin
    for (int c = 0; c < 3; c++) carry_tmo[c] = 1'b0;
    rst = 1'b0; sr_req = '0; sr_all = 1'b0; idle = '1; l_req = '0; l_idle = '1;

    // Reset state, then quiet cycles.
    clear_scen();
    apply_rst(0, 2);
    run_scen(0);

    // Single request on channel 0 with idle already high.
    clear_scen();
    st_req[2] = 2'b01;
    plan(0, 2, 1, 4, 1'b0);
    run_scen(1);

    // Timeout on channel 1, sticky tmo, then cleared by a clean sequence.
    clear_scen();
    for (int k = 0; k < 18; k++) st_idle[k] = 2'b01;
    st_req[2]  = 2'b10;
    st_req[20] = 2'b10;
    plan(1, 2, 8, 4, 1'b1);
    plan(1, 20, 1, 4, 1'b0);
    run_scen(2);

    // sr_all starts both; later sr_all ignored by a busy channel; idle glitches in RESET.
    clear_scen();
    st_all[2]  = 1'b1;
    plan(0, 2, 1, 4, 1'b0);
    plan(1, 2, 1, 4, 1'b0);
    st_req[20] = 2'b10;
    st_all[22] = 1'b1;
    for (int k = 24; k < 28; k++) st_idle[k] = 2'b10;
    plan(1, 20, 1, 4, 1'b0);
    plan(0, 22, 1, 4, 1'b0);
    run_scen(3);

    // Re-pulse during RESET ignored; held request retriggers after one IDLE cycle.
    clear_scen();
    st_req[2] = 2'b01;
    st_req[5] = 2'b01;
    for (int k = 12; k <= 24; k++) st_req[k] = 2'b01;
    plan(0, 2, 1, 4, 1'b0);
    plan(0, 12, 1, 4, 1'b0);
    plan(0, 19, 1, 4, 1'b0);
    run_scen(4);

    // rst mid-sequence kills both channels and tmo; requests during rst ignored.
    clear_scen();
    for (int k = 0; k < NCYC; k++) st_idle[k] = 2'b01;
    st_req[0]  = 2'b10;
    st_req[8]  = 2'b01;
    st_req[12] = 2'b01;
    st_req[20] = 2'b01;
    plan(1, 0, 8, 4, 1'b1);
    plan(0, 8, 1, 4, 1'b0);
    apply_rst(11, 12);
    plan(0, 20, 1, 4, 1'b0);
    run_scen(5);

    // RST_CYC=1, TMO_CYC=1 instance: timeout then clean legacy-style sequence.
    clear_scen();
    for (int k = 0; k < 6; k++) st_lidle[k] = 1'b0;
    st_lreq[2] = 1'b1;
    st_lreq[8] = 1'b1;
    plan(2, 2, 1, 1, 1'b1);
    plan(2, 8, 1, 1, 1'b0);
    run_scen(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
